// File: rtl/round_scheduler_pkg.sv
// round_sched_pkg: shared FSM state encoding and banner ids for the round scheduler
package round_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REGEN,
        COUNTDOWN,
        RUN,
        PAUSED,
        WIN,
        LOSE,
        FAULT
    } state_e;

    localparam int unsigned BANNER_TITLE = 0;
    localparam int unsigned BANNER_WIN   = 1;
    localparam int unsigned BANNER_LOSE  = 2;
    localparam int unsigned BANNER_FAULT = 3;

endpackage

// File: rtl/round_scheduler_sec_tick_gen.sv
// sec_tick_gen: one-cycle tick every TICK_DIV enabled cycles, counter held at zero while disabled
module sec_tick_gen
    import round_sched_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_tick = i_en && (cnt_q == CW'(TICK_DIV - 1));

    // Count while enabled, wrap on tick, restart from zero whenever disabled
    always_comb cnt_d = (!i_en || o_tick) ? '0 : cnt_q + 1'b1;

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/round_scheduler.sv
// round_scheduler: round sequencing FSM (regen handshake, countdown, run/pause, win/lose, rating); option ROUND_SCHED_AUTO_ADVANCE_EN
module round_scheduler
    import round_sched_pkg::*;
#(
    parameter int RATING_WIDTH  = 8,
    parameter int NUM_IMAGES    = 4,
    parameter int TICK_DIV      = 25_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int READY_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic                          i_pause,
    input  logic                          i_win,
    input  logic                          i_lose,
    input  logic                          i_ready,
    output logic                          o_regen,
    output logic                          o_game_running,
    output logic [$clog2(NUM_IMAGES)-1:0] o_banner_num,
    output logic [3:0]                    o_countdown,
    output logic [RATING_WIDTH-1:0]       o_rating,
    output logic                          o_fault
);

    localparam int BW = $clog2(NUM_IMAGES);
    localparam int TW = $clog2(READY_TIMEOUT);

    state_e                  state_q, state_d;
    logic                    start_q;
    logic                    start_edge;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [3:0]              cd_q, cd_d;
    logic [RATING_WIDTH-1:0] rating_q, rating_d;
    logic                    regen_q, regen_d;
    logic                    run_q, run_d;
    logic                    fault_q, fault_d;
    logic [BW-1:0]           banner_q, banner_d;
    logic                    tick;
    logic                    tick_en;
`ifdef ROUND_SCHED_AUTO_ADVANCE_EN
    logic                    win_tick_q, win_tick_d;

    assign tick_en = (state_q == COUNTDOWN) || (state_q == WIN);
`else
    assign tick_en = (state_q == COUNTDOWN);
`endif

    assign start_edge = i_start & ~start_q;

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (tick_en),
        .o_tick (tick)
    );

    // Next-state, timeout counter and rating update
    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        rating_d = rating_q;
`ifdef ROUND_SCHED_AUTO_ADVANCE_EN
        win_tick_d = 1'b0;
`endif
        case (state_q)
            IDLE, LOSE, FAULT: if (start_edge) state_d = REGEN;
            REGEN: begin
                tmo_d = tmo_q + 1'b1;
                if (i_ready && !regen_q)                 state_d = COUNTDOWN;
                else if (tmo_q == TW'(READY_TIMEOUT - 1)) state_d = FAULT;
            end
            COUNTDOWN: if (tick && cd_q == 4'd1) state_d = RUN;
            RUN: begin
                if (i_lose) begin
                    state_d  = LOSE;
                    rating_d = '0;
                end else if (i_win) begin
                    state_d  = WIN;
                    rating_d = (&rating_q) ? rating_q : rating_q + 1'b1;
                end else if (i_pause) begin
                    state_d  = PAUSED;
                end
            end
            PAUSED: if (!i_pause) state_d = COUNTDOWN;
            WIN: begin
`ifdef ROUND_SCHED_AUTO_ADVANCE_EN
                win_tick_d = win_tick_q | tick;
                if (start_edge || (tick && win_tick_q)) state_d = REGEN;
`else
                if (start_edge) state_d = REGEN;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs derived from the upcoming state
    always_comb begin
        regen_d  = (state_d == REGEN) && (state_q != REGEN);
        run_d    = (state_d == RUN);
        cd_d     = (state_d != COUNTDOWN) ? 4'd0 :
                   (state_q != COUNTDOWN) ? 4'(COUNTDOWN_SEC) :
                   tick                   ? cd_q - 4'd1 : cd_q;
        fault_d  = (state_d == FAULT) || (fault_q && !start_edge);
        banner_d = (state_d == WIN)   ? BW'(BANNER_WIN)   :
                   (state_d == LOSE)  ? BW'(BANNER_LOSE)  :
                   (state_d == FAULT) ? BW'(BANNER_FAULT) : BW'(BANNER_TITLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            tmo_q    <= '0;
            cd_q     <= '0;
            rating_q <= '0;
            regen_q  <= 1'b0;
            run_q    <= 1'b0;
            fault_q  <= 1'b0;
            banner_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= i_start;
            tmo_q    <= tmo_d;
            cd_q     <= cd_d;
            rating_q <= rating_d;
            regen_q  <= regen_d;
            run_q    <= run_d;
            fault_q  <= fault_d;
            banner_q <= banner_d;
        end
    end

`ifdef ROUND_SCHED_AUTO_ADVANCE_EN
    // Remembers the first second elapsed in WIN so the second one advances
    always_ff @(posedge clk) begin
        if (!rst_n) win_tick_q <= 1'b0;
        else        win_tick_q <= win_tick_d;
    end
`endif

    assign o_regen        = regen_q;
    assign o_game_running = run_q;
    assign o_banner_num   = banner_q;
    assign o_countdown    = cd_q;
    assign o_rating       = rating_q;
    assign o_fault        = fault_q;

endmodule
